axil_frame_fill_master: RTL and testbench

- AXI4-Lite initiator that fills the pixel frame buffer through the AXI-Lite BRAM slave, one single-beat write per pixel.
- Software or a test controller loads base address, pixel count, pattern mode and fill byte, then pulses start.
- The block generates the pixel stream, runs the AW/W/B handshakes, counts write errors and reports done.
- Sits between the system controller and the existing AXI-Lite BRAM/VGA slave, on the same clock domain.

---
 rtl/axil_frame_fill_master.sv | 154 +++++++++++++++
 tb/tb_axil_frame_fill_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_frame_fill_master.sv
// axil_frame_fill_master: AXI4-Lite initiator writing one pixel per single-beat transaction.
// Define READBACK_VERIFY_EN to read each pixel back and count mismatches.
module axil_frame_fill_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 17,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_START,
    input  logic [ADDR_W-1:0]   i_BASE_ADDR,
    input  logic [CNT_W-1:0]    i_NUM_PIX,
    input  logic [1:0]          i_MODE,
    input  logic [7:0]          i_FILL,
    output logic                o_BUSY,
    output logic                o_DONE,
    output logic [CNT_W-1:0]    o_ERR_CNT,
    output logic [ADDR_W-1:0]   M_AWADDR,
    output logic                M_AWVALID,
    input  logic                M_AWREADY,
    output logic [DATA_W-1:0]   M_WDATA,
    output logic [DATA_W/8-1:0] M_WSTRB,
    output logic                M_WVALID,
    input  logic                M_WREADY,
    input  logic [1:0]          M_BRESP,
    input  logic                M_BVALID,
    output logic                M_BREADY,
    output logic [ADDR_W-1:0]   M_ARADDR,
    output logic                M_ARVALID,
    input  logic                M_ARREADY,
    input  logic [DATA_W-1:0]   M_RDATA,
    input  logic [1:0]          M_RRESP,
    input  logic                M_RVALID,
    output logic                M_RREADY
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RESP = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef READBACK_VERIFY_EN
    localparam logic [2:0] S_RD   = 3'd5;
`endif

    logic [2:0]        state;
    logic [CNT_W-1:0]  k, num, err;
    logic [1:0]        mode;
    logic [7:0]        fill, pix;
    logic [ADDR_W-1:0] addr;
    logic              aw_valid, w_valid;

    function automatic logic [7:0] pix_byte(input logic [1:0] m, input logic [7:0] f,
                                            input logic [CNT_W-1:0] i);
        return m == 2'd0 ? f : m == 2'd1 ? i[7:0] : m == 2'd2 ? f ^ {8{i[3]}} : f + i[7:0];
    endfunction

    // a channel counts as done once its valid has dropped or it handshakes this cycle
    logic aw_done, w_done;
    assign aw_done = !aw_valid || M_AWREADY;
    assign w_done  = !w_valid || M_WREADY;

    assign o_BUSY    = state != S_IDLE && state != S_DONE;
    assign o_DONE    = state == S_DONE;
    assign o_ERR_CNT = err;
    assign M_AWADDR  = addr;
    assign M_AWVALID = aw_valid;
    assign M_WDATA   = {{(DATA_W-8){1'b0}}, pix};
    assign M_WSTRB   = {{(DATA_W/8-1){1'b0}}, 1'b1};
    assign M_WVALID  = w_valid;
    assign M_BREADY  = state == S_RESP;

`ifdef READBACK_VERIFY_EN
    logic ar_valid;
    logic unused_rd;
    assign unused_rd = ^M_RDATA[DATA_W-1:8];
    assign M_ARADDR  = addr;
    assign M_ARVALID = ar_valid;
    assign M_RREADY  = state == S_RD && !ar_valid;
`else
    logic unused_rd;
    assign unused_rd = ^{M_ARREADY, M_RDATA, M_RRESP, M_RVALID};
    assign M_ARADDR  = '0;
    assign M_ARVALID = 1'b0;
    assign M_RREADY  = 1'b0;
`endif

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state    <= S_IDLE;
            k        <= '0;
            num      <= '0;
            err      <= '0;
            mode     <= '0;
            fill     <= '0;
            pix      <= '0;
            addr     <= '0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
`ifdef READBACK_VERIFY_EN
            ar_valid <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (i_START) begin
                    num      <= i_NUM_PIX;
                    mode     <= i_MODE;
                    fill     <= i_FILL;
                    addr     <= i_BASE_ADDR;
                    k        <= '0;
                    err      <= '0;
                    pix      <= pix_byte(i_MODE, i_FILL, '0);
                    state    <= i_NUM_PIX == '0 ? S_DONE : S_WR;
                    aw_valid <= i_NUM_PIX != '0;
                    w_valid  <= i_NUM_PIX != '0;
                end
                S_WR: begin
                    if (M_AWREADY) aw_valid <= 1'b0;
                    if (M_WREADY) w_valid <= 1'b0;
                    if (aw_done && w_done) state <= S_RESP;
                end
                S_RESP: if (M_BVALID) begin
                    if (M_BRESP != 2'b00 && err != '1) err <= err + 1'b1;
`ifdef READBACK_VERIFY_EN
                    ar_valid <= 1'b1;
                    state    <= S_RD;
`else
                    state    <= S_NEXT;
`endif
                end
`ifdef READBACK_VERIFY_EN
                S_RD: begin
                    if (M_ARREADY) ar_valid <= 1'b0;
                    if (!ar_valid && M_RVALID) begin
                        if ((M_RRESP != 2'b00 || M_RDATA[7:0] != pix) && err != '1) err <= err + 1'b1;
                        state <= S_NEXT;
                    end
                end
`endif
                S_NEXT: if (k == num - 1'b1) begin
                    state <= S_DONE;
                end else begin
                    k        <= k + 1'b1;
                    addr     <= addr + ADDR_W'(ADDR_STRIDE);
                    pix      <= pix_byte(mode, fill, k + 1'b1);
                    aw_valid <= 1'b1;
                    w_valid  <= 1'b1;
                    state    <= S_WR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_frame_fill_master.sv
// tb_axil_frame_fill_master: table-driven and randomized runs against a behavioural AXI-Lite slave and pixel model.
module tb_axil_frame_fill_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [16:0] num_pix = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  fill = '0;
    logic        busy, done;
    logic [16:0] err_cnt;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axil_frame_fill_master dut (
        .i_CLK(clk), .i_RST(rst), .i_START(start), .i_BASE_ADDR(base_addr), .i_NUM_PIX(num_pix),
        .i_MODE(mode), .i_FILL(fill), .o_BUSY(busy), .o_DONE(done), .o_ERR_CNT(err_cnt),
        .M_AWADDR(awaddr), .M_AWVALID(awvalid), .M_AWREADY(awready), .M_WDATA(wdata), .M_WSTRB(wstrb),
        .M_WVALID(wvalid), .M_WREADY(wready), .M_BRESP(bresp), .M_BVALID(bvalid), .M_BREADY(bready),
        .M_ARADDR(araddr), .M_ARVALID(arvalid), .M_ARREADY(arready), .M_RDATA(rdata), .M_RRESP(rresp),
        .M_RVALID(rvalid), .M_RREADY(rready)
    );

    int          aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] err_mask = '0, rd_mask = '0;
    int          aw_cnt, w_cnt, b_wait, b_cnt, proto_err, done_cnt;
    logic        got_aw, got_w, pend_aw, pend_w;
    logic [31:0] pend_addr, pend_data;
    logic [31:0] cap_addr[$], cap_data[$], ar_q[$];
    logic [3:0]  cap_strb[$];
    int          aw_lens[$], w_lens[$];

    assign awready = aw_cnt >= aw_delay;
    assign wready  = w_cnt >= w_delay;

    // slave model: programmable ready delays, B latency, per-pixel SLVERR and protocol checks
    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; b_wait <= 0; b_cnt <= 0; done_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            pend_aw <= 1'b0; pend_w <= 1'b0; pend_addr <= '0; pend_data <= '0;
            cap_addr.delete(); cap_data.delete(); cap_strb.delete(); ar_q.delete();
            aw_lens.delete(); w_lens.delete();
        end else begin
            proto_err <= proto_err + int'(awvalid && awready && (got_aw || bvalid))
                                   + int'(wvalid && wready && (got_w || bvalid))
                                   + int'(pend_aw && (!awvalid || awaddr != pend_addr))
                                   + int'(pend_w && (!wvalid || wdata != pend_data));
            pend_aw <= awvalid && !awready;
            pend_w <= wvalid && !wready;
            pend_addr <= awaddr;
            pend_data <= wdata;
            if (done) done_cnt <= done_cnt + 1;
            if (awvalid && awready) begin
                aw_cnt <= 0; got_aw <= 1'b1;
                cap_addr.push_back(awaddr); aw_lens.push_back(aw_cnt + 1);
            end else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin
                w_cnt <= 0; got_w <= 1'b1;
                cap_data.push_back(wdata); cap_strb.push_back(wstrb); w_lens.push_back(w_cnt + 1);
            end else if (wvalid) w_cnt <= w_cnt + 1;
            if (got_aw && got_w && !bvalid) begin
                if (b_wait >= b_delay) begin
                    bvalid <= 1'b1;
                    bresp <= (b_cnt < 32 && err_mask[b_cnt]) ? 2'b10 : 2'b00;
                end else b_wait <= b_wait + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0; b_wait <= 0; b_cnt <= b_cnt + 1;
            end
        end
    end

`ifdef READBACK_VERIFY_EN
    assign arready = 1'b1;
    always @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
        end else begin
            if (arvalid && arready) begin
                ar_q.push_back(araddr);
                rvalid <= 1'b1;
                rresp <= 2'b00;
                rdata <= {24'h0, cap_data[b_cnt-1][7:0] ^ (rd_mask[b_cnt-1] ? 8'h5A : 8'h00)};
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end
`else
    assign arready = 1'b0;
    assign rvalid  = 1'b0;
    assign rdata   = '0;
    assign rresp   = 2'b00;
`endif

    int nvec = 0, nfail = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int m, input logic [7:0] f, input int k);
        case (m)
            0: return f;
            1: return 8'(k % 256);
            2: return ((k / 8) % 2) ? ~f : f;
            default: return 8'((int'(f) + k) % 256);
        endcase
    endfunction

    function automatic int ref_err(input int n, input logic [31:0] em, input logic [31:0] rm);
        int e = 0;
        for (int i = 0; i < n && i < 32; i++) begin
            if (em[i]) e++;
`ifdef READBACK_VERIFY_EN
            if (rm[i]) e++;
`endif
        end
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_case(input logic [31:0] b, input int n, input int m, input logic [7:0] f,
                            input int awd, input int wd, input int bd, input logic [31:0] em,
                            input logic [31:0] rm, input int exp_err, input bit restart);
        int lat, pe0;
        aw_delay = awd; w_delay = wd; b_delay = bd; err_mask = em; rd_mask = rm;
        do_reset();
        pe0 = proto_err;
        base_addr = b; num_pix = 17'(n); mode = 2'(m); fill = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = 32'hDEAD_BEE0; num_pix = 17'd1; mode = 2'(m + 1); fill = ~f;
        lat = 1;
        while (!done && lat < 3000) begin
            start = restart && lat == 3;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", 96'(done), 96'(1));
        if (n == 0) chk("zero_latency", 96'(lat), 96'(1));
        @(negedge clk);
        @(negedge clk);
        chk("done_pulses", 96'(done_cnt), 96'(1));
        chk("busy_after", 96'({busy, done}), 96'(0));
        chk("write_count", 96'(cap_addr.size()), 96'(n));
        chk("err_cnt", 96'(err_cnt), 96'(exp_err));
        chk("proto", 96'(proto_err - pe0), 96'(0));
        if (n > 0) chk("valid_lens", 96'({aw_lens[0], w_lens[0]}), 96'({awd + 1, wd + 1}));
        for (int i = 0; i < n && i < cap_addr.size(); i++)
            chk($sformatf("pixel%0d", i), {cap_addr[i], cap_data[i], 28'(cap_strb[i])},
                {b + 32'(i * 4), 24'h0, ref_byte(m, f, i), 28'h1});
`ifdef READBACK_VERIFY_EN
        chk("ar_count", 96'(ar_q.size()), 96'(n));
        for (int i = 0; i < n && i < ar_q.size(); i++)
            chk($sformatf("araddr%0d", i), 96'(ar_q[i]), 96'(b + 32'(i * 4)));
`endif
    endtask

    typedef struct {
        logic [31:0] base;
        int          n;
        int          m;
        logic [7:0]  f;
        int          awd, wd, bd;
        logic [31:0] em;
        int          exp_err;
        bit          restart;
    } vec_t;

    vec_t tbl[6];

    initial begin
        proto_err = 0;
        tbl[0] = '{32'h0000_1000, 5, 1, 8'h00, 0, 0, 1, 32'h0, 0, 1'b0};
        tbl[1] = '{32'h0000_2000, 3, 0, 8'h33, 3, 0, 0, 32'h0, 0, 1'b0};
        tbl[2] = '{32'h0000_3000, 4, 0, 8'hA5, 0, 0, 0, 32'hA, 2, 1'b0};
        tbl[3] = '{32'h0000_4000, 16, 2, 8'h0F, 0, 1, 2, 32'h0, 0, 1'b1};
        tbl[4] = '{32'hFFFF_FFF8, 4, 3, 8'hF0, 1, 2, 0, 32'h5, 2, 1'b0};
        tbl[5] = '{32'h0000_0100, 0, 0, 8'h77, 0, 0, 0, 32'h0, 0, 1'b1};

        do_reset();
        chk("reset_state", {awvalid, wvalid, bready, arvalid, rready, busy, done, err_cnt, awaddr, wdata},
            96'(0));

        foreach (tbl[i])
            run_case(tbl[i].base, tbl[i].n, tbl[i].m, tbl[i].f, tbl[i].awd, tbl[i].wd, tbl[i].bd,
                     tbl[i].em, 32'h0, tbl[i].exp_err, tbl[i].restart);

`ifdef READBACK_VERIFY_EN
        run_case(32'h0000_5000, 3, 1, 8'h00, 0, 0, 0, 32'h0, 32'h4, 1, 1'b0);
`endif

        for (int r = 0; r < 20; r++) begin
            logic [31:0] b, em, rm;
            int n, m;
            b = $urandom; em = $urandom; rm = $urandom;
            n = $urandom_range(1, 20); m = $urandom_range(0, 3);
`ifndef READBACK_VERIFY_EN
            rm = '0;
`endif
            run_case(b, n, m, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), em, rm, ref_err(n, em, rm), 1'b0);
        end

        // reset asserted while a write is stalled on AWREADY
        aw_delay = 20; w_delay = 0; b_delay = 0; err_mask = '0;
        do_reset();
        base_addr = 32'h0000_6000; num_pix = 17'd5; mode = 2'd1; fill = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_reset_awvalid", 96'({awvalid, busy}), 96'(2'b11));
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_reset", {awvalid, wvalid, bready, busy, done, err_cnt}, 96'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {awvalid, wvalid, busy, done}, 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
